// File: rtl/fetch_unit.sv
// Instruction fetch unit: in-order prefetch into a small FIFO with redirect flush.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int unsigned       DWIDTH     = 32,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [DWIDTH-1:0] RESET_PC   = DWIDTH'(32'h0000_0000)
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core,
    output logic              Imem_Req,
    output logic [DWIDTH-1:0] Imem_Addr,
    input  logic              Imem_Gnt,
    input  logic              Imem_Rvalid,
    input  logic [31:0]       Imem_Rdata,
    output logic              Instr_Valid,
    output logic [31:0]       Instr,
    output logic [DWIDTH-1:0] Instr_Pc,
    input  logic              Instr_Ready,
    input  logic              Redirect_Valid,
    input  logic [DWIDTH-1:0] Redirect_Pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       Perf_Fetched,
    output logic [31:0]       Perf_Stall,
    output logic [31:0]       Perf_Flush
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {FETCH, FLUSH} state_t;

    state_t            state;
    logic [DWIDTH-1:0] fetch_pc;
    logic [DWIDTH-1:0] rsp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     stale;
    logic [CW-1:0]     fifo_count;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [31:0]       mem_instr [FIFO_DEPTH];
    logic [DWIDTH-1:0] mem_pc    [FIFO_DEPTH];

    logic [CW:0]       occupancy;
    logic [CW-1:0]     in_flight;
    logic [CW-1:0]     stale_next;
    logic [DWIDTH-1:0] redirect_target;
    logic              fifo_valid;
    logic              accept;
    logic              rsp_live;
    logic              push;
    logic              pop;

    // Requests are throttled so every in-flight response is guaranteed a FIFO slot.
    assign occupancy       = (CW+1)'(outstanding) + (CW+1)'(fifo_count);
    assign Imem_Req        = !Rst_Core && (state == FETCH) && !Redirect_Valid
                             && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign Imem_Addr       = Rst_Core ? RESET_PC : fetch_pc;
    assign accept          = Imem_Req && Imem_Gnt;

    assign fifo_valid      = !Rst_Core && (fifo_count != '0);
    assign Instr_Valid     = fifo_valid;
    assign Instr           = fifo_valid ? mem_instr[rd_ptr] : '0;
    assign Instr_Pc        = fifo_valid ? mem_pc[rd_ptr] : '0;

    // Only one of outstanding/stale is ever non-zero, so their sum is the in-flight count.
    assign in_flight       = outstanding + stale;
    assign rsp_live        = Imem_Rvalid && (in_flight != '0);
    assign push            = rsp_live && (state == FETCH) && !Redirect_Valid;
    assign pop             = fifo_valid && Instr_Ready && !Redirect_Valid;
    assign stale_next      = in_flight + CW'(accept) - CW'(rsp_live);
    assign redirect_target = Redirect_Pc & ~DWIDTH'(3);

    // Control state, fetch/response PCs, counters and FIFO pointers.
    always_ff @(posedge Clk_Core) begin
        if (Rst_Core) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            stale       <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (Redirect_Valid) begin
            fetch_pc    <= redirect_target;
            rsp_pc      <= redirect_target;
            outstanding <= '0;
            stale       <= stale_next;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            state       <= (stale_next == '0) ? FETCH : FLUSH;
        end else begin
            case (state)
                FETCH: begin
                    if (accept) fetch_pc <= fetch_pc + DWIDTH'(4);
                    if (push) begin
                        rsp_pc <= rsp_pc + DWIDTH'(4);
                        wr_ptr <= wr_ptr + AW'(1);
                    end
                    if (pop) rd_ptr <= rd_ptr + AW'(1);
                    outstanding <= outstanding + CW'(accept) - CW'(rsp_live);
                    fifo_count  <= fifo_count + CW'(push) - CW'(pop);
                end
                FLUSH: begin
                    if (rsp_live) begin
                        stale <= stale - CW'(1);
                        if (stale == CW'(1)) state <= FETCH;
                    end
                end
            endcase
        end
    end

    // FIFO storage needs no reset; validity is tracked by fifo_count.
    always_ff @(posedge Clk_Core) begin
        if (!Rst_Core && push) begin
            mem_instr[wr_ptr] <= Imem_Rdata;
            mem_pc[wr_ptr]    <= rsp_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge Clk_Core) begin
        if (Rst_Core) begin
            Perf_Fetched <= '0;
            Perf_Stall   <= '0;
            Perf_Flush   <= '0;
        end else begin
            if (pop)                         Perf_Fetched <= Perf_Fetched + 32'd1;
            if (Instr_Ready && !fifo_valid) Perf_Stall   <= Perf_Stall + 32'd1;
            if (Redirect_Valid)              Perf_Flush   <= Perf_Flush + 32'd1;
        end
    end
`endif

endmodule
